// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types, including the hazard scoreboard entry and forwarding constants
package cpu_pkg;
  localparam int REG_ADDR_MAX_W = 8;
  localparam int FWD_REGFILE = 0;
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_MAX_W-1:0] rd;
    logic                      we;
    logic                      is_load;
  } hazard_entry_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: per-port priority encoder over the scoreboard, youngest match wins; sb[k-1] is stage k; outputs sel (0 = regfile) and load_block (youngest match is a load too young to forward)
module hazard_match
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 2,
  parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
  input  hazard_entry_t [NUM_STAGES-1:0] sb,
  input  logic [REG_ADDR_W-1:0]          rs,
  output logic [SEL_W-1:0]               sel,
  output logic                           load_block
);
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    load_block = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (sb[k-1].valid && sb[k-1].we && sb[k-1].rd != '0 && sb[k-1].rd == REG_ADDR_MAX_W'(rs)) begin
        load_block = sb[k-1].is_load && k < LOAD_LATENCY;
        sel = load_block ? SEL_W'(FWD_REGFILE) : SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based forwarding/load-use/flush/freeze controller; optional perf counters o_stall_cycles/o_fwd_count with HAZARD_PERF_EN; ports: i_clk, i_rst_n, issue candidate, i_flush, i_mem_ready -> o_issue_accept, o_stall, o_fwd_sel
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LATENCY   = 2,
  parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_issue_valid,
  input  logic [REG_ADDR_W-1:0]                i_issue_rd,
  input  logic                                 i_issue_rd_we,
  input  logic                                 i_issue_is_load,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] i_issue_rs,
  input  logic                                 i_flush,
  input  logic                                 i_mem_ready,
  output logic                                 o_issue_accept,
  output logic                                 o_stall,
  output logic [NUM_READ_PORTS*SEL_W-1:0]      o_fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                          o_stall_cycles,
  output logic [31:0]                          o_fwd_count
`endif
);
  hazard_entry_t [NUM_STAGES-1:0] sb;
  hazard_entry_t                  cand;
  logic [NUM_READ_PORTS-1:0]      blk;
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    hazard_match #(
      .NUM_STAGES  (NUM_STAGES),
      .REG_ADDR_W  (REG_ADDR_W),
      .LOAD_LATENCY(LOAD_LATENCY),
      .SEL_W       (SEL_W)
    ) u_match (
      .sb        (sb),
      .rs        (i_issue_rs[p*REG_ADDR_W +: REG_ADDR_W]),
      .sel       (o_fwd_sel[p*SEL_W +: SEL_W]),
      .load_block(blk[p])
    );
  end
  assign o_stall = i_issue_valid & ~i_flush & (|blk);
  assign o_issue_accept = i_issue_valid & ~i_flush & ~o_stall & i_mem_ready;
  assign cand = '{valid: 1'b1, rd: REG_ADDR_MAX_W'(i_issue_rd), we: i_issue_rd_we, is_load: i_issue_is_load};
  // A rejected candidate (stall or flush) enters as a bubble; the whole chain freezes on memory wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb <= '0;
    end else if (i_mem_ready) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) sb[k] <= sb[k-1];
      sb[0] <= o_issue_accept ? cand : '0;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_fwd_count <= '0;
    end else begin
      if (o_stall && i_mem_ready && ~&o_stall_cycles) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (o_issue_accept && |o_fwd_sel && ~&o_fwd_count) o_fwd_count <= o_fwd_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit with default parameters
module tb_hazard_unit;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       valid = 1'b0, we = 1'b0, ld = 1'b0, flush = 1'b0, ready = 1'b1;
  logic [4:0] rd = '0;
  logic [9:0] rs = '0;
  logic       accept, stall;
  logic [3:0] fwd;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, fwd_count;
`endif
  int checks = 0, errors = 0;
  hazard_unit dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_issue_valid  (valid),
    .i_issue_rd     (rd),
    .i_issue_rd_we  (we),
    .i_issue_is_load(ld),
    .i_issue_rs     (rs),
    .i_flush        (flush),
    .i_mem_ready    (ready),
    .o_issue_accept (accept),
    .o_stall        (stall),
    .o_fwd_sel      (fwd)
`ifdef HAZARD_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_fwd_count    (fwd_count)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk(input string tag, input logic s, input logic a, input logic [3:0] f);
    check({tag, "_stall"}, 32'(stall), 32'(s));
    check({tag, "_accept"}, 32'(accept), 32'(a));
    check({tag, "_fwd"}, 32'(fwd), 32'(f));
  endtask
  task automatic drive(input logic v, input logic [4:0] d, input logic w, input logic l,
                       input logic [4:0] s0, input logic [4:0] s1, input logic f, input logic r);
    valid = v; rd = d; we = w; ld = l; rs = {s1, s0}; flush = f; ready = r;
    #1;
  endtask
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    drive(1, 5, 1, 0, 5, 5, 0, 1);
    chk("rst", 0, 1, 4'h0);
    drive(1, 5, 1, 0, 5, 5, 0, 0);
    chk("rst_frz", 0, 0, 4'h0);
    step;
    i_rst_n = 1'b1;
    drive(1, 5, 1, 1, 0, 0, 0, 1);
    chk("ld_issue", 0, 1, 4'h0);
    step;
    drive(1, 6, 1, 0, 5, 0, 0, 1);
    chk("lu_stall", 1, 0, 4'h0);
    step;
    chk("lu_fwd", 0, 1, 4'h2);
    step;
    drive(1, 7, 1, 0, 1, 5, 0, 1);
    chk("ld_age3", 0, 1, 4'hC);
    step;
    drive(1, 8, 1, 0, 7, 7, 0, 1);
    chk("b2b", 0, 1, 4'h5);
    step;
    drive(1, 3, 1, 0, 0, 0, 0, 1); step;
    drive(1, 9, 1, 0, 0, 0, 0, 1); step;
    drive(1, 3, 1, 0, 0, 0, 0, 1); step;
    drive(0, 0, 0, 0, 3, 9, 0, 1);
    chk("youngest", 0, 0, 4'h9);
    drive(1, 0, 1, 0, 0, 0, 0, 1); step; step; step;
    drive(0, 0, 0, 0, 0, 3, 0, 1);
    chk("x0", 0, 0, 4'h0);
    drive(1, 4, 1, 0, 0, 0, 0, 1); step;
    drive(1, 0, 0, 0, 0, 0, 0, 1); step;
    drive(1, 4, 1, 1, 0, 0, 0, 1); step;
    drive(1, 11, 1, 0, 4, 0, 0, 1);
    chk("blk", 1, 0, 4'h0);
    step;
    chk("blk_rel", 0, 1, 4'h2);
    step;
    drive(1, 5, 1, 1, 0, 0, 0, 1); step;
    for (int i = 0; i < 3; i++) begin
      drive(1, 12, 1, 0, 0, 5, 0, 0);
      chk("frz", 1, 0, 4'h0);
      step;
    end
    drive(1, 12, 1, 0, 0, 5, 0, 1);
    chk("frz_rel", 1, 0, 4'h0);
    step;
    chk("frz_fwd", 0, 1, 4'h8);
    step;
    drive(1, 5, 1, 1, 0, 0, 0, 1); step;
    drive(1, 10, 1, 0, 5, 0, 1, 1);
    chk("flush", 0, 0, 4'h0);
    step;
    drive(1, 13, 1, 0, 5, 10, 0, 1);
    chk("flush_bub", 0, 1, 4'h2);
    step;
    drive(1, 5, 1, 1, 0, 0, 0, 1); step;
    drive(1, 14, 1, 0, 5, 0, 0, 1);
    chk("pre_rst", 1, 0, 4'h0);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst", 0, 1, 4'h0);
`ifdef HAZARD_PERF_EN
    check("rst_stall_cnt", stall_cycles, 32'd0);
    check("rst_fwd_cnt", fwd_count, 32'd0);
`endif
    step;
    i_rst_n = 1'b1;
    #1;
    chk("post_rst", 0, 1, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
